ps2_rx_fifo: RTL and testbench
==============================

// Module: ps2_rx_fifo
// PURPOSE
//  PS/2 device-to-host receiver. Sits between the PS/2 debouncer and the SoC keyboard port.
//  Synchronises the debounced ps2Clk/ps2Data lines into the SoC clock domain.
//  Deframes 11-bit PS/2 frames, checks parity and stop bit, and queues good bytes in a
//  small FIFO that the CPU reads through a pop strobe.
// PARAMETERS
//  FIFO_AW         2      log2 of FIFO depth (depth = 4 bytes)
//  TIMEOUT_CYCLES  20000  max clk cycles between ps2Clk falling edges inside one frame
// PORTS
//  clk        in   1          SoC clock; all logic on rising edge
//  reset      in   1          synchronous, active-high
//  ps2Clk     in   1          debounced PS/2 clock, asynchronous to clk
//  ps2Data    in   1          debounced PS/2 data, asynchronous to clk
//  rdStrobe   in   1          pop head byte (1-cycle pulse); ignored when FIFO is empty
//  errClr     in   1          clears rxError and overflow
//  rxData     out  8          FIFO head byte; valid only while rxValid=1
//  rxValid    out  1          FIFO not empty
//  rxError    out  1          sticky: parity, stop-bit or timeout error seen
//  overflow   out  1          sticky: good byte dropped because FIFO was full
//  fifoCount  out  FIFO_AW+1  number of queued bytes, 0..2^FIFO_AW
// BEHAVIOUR
//  Reset
//  - All outputs are 0. FIFO is empty. FSM is IDLE.
//  - Synchroniser flops reset to 1 (idle line). Bit counter and timeout counter reset to 0.
//  - A reset mid-frame discards the partial frame and flags no error.
//  Input sampling and edge detection
//  - Each input passes through 2-flop sync s1,s2. ps2Clk s2 is delayed once more to form prev.
//  - fall = prev & ~s2. Data is sampled from synchronised ps2Data s2 in the fall cycle.
//  FSM (advances only on fall, except timeout)
//  - IDLE: on fall, data=0 -> DATA with bitCnt=0. Data=1 is a bad start bit: stay IDLE, no error.
//  - DATA: shift data in LSB first. After the 8th bit -> PARITY.
//  - PARITY: store the bit -> STOP.
//  - STOP: go to IDLE. Frame is good when stop=1 and the 9 data+parity bits have odd
//    population count.
//    - Good frame: push the byte.
//    - Bad frame: discard the byte and set rxError.
//  - Timeout: in any non-IDLE state, a counter clears on fall and increments otherwise.
//    Reaching TIMEOUT_CYCLES -> IDLE, discard the frame, set rxError.
//  FIFO
//  - Push happens in the STOP fall cycle. rxValid and fifoCount update on the next clock edge.
//  - Latency: ps2Clk low set up before clk edge 1 -> the push occurs at edge 3.
//    rxValid is high after edge 3.
//  - Pop on rdStrobe & rxValid: the head advances and fifoCount decrements at the next edge.
//  - Push while full without a pop: the byte is dropped, overflow is set, and FIFO contents
//    are unchanged.
//  - Push and pop in the same cycle: both are performed and fifoCount is unchanged.
//    When full, the push is accepted with no overflow.
//  - Pointers wrap modulo 2^FIFO_AW. rxData is combinational from mem[rdPtr].
//  Sticky flags
//  - errClr clears the flags at the next edge.
//  - If a set event and errClr occur in the same cycle, set wins.
// TESTING
//  - Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> rxData=0x1C,
//    rxValid=1 at edge 3 after the last fall, fifoCount=1.
//  - Frame 0x1C with parity 1 -> no push, fifoCount=0, rxError=1.
//    errClr pulse -> rxError=0.
//  - Frame 0x5A with stop bit 0 -> no push, rxError=1.
//  - 4 data bits of a frame, then idle for TIMEOUT_CYCLES+5 -> IDLE, rxError=1.
//    A following frame 0xF0 (parity 1) is received correctly.
//  - 5 frames 0x01..0x05 with no reads -> fifoCount=4, overflow=1.
//    Reads return 0x01,0x02,0x03,0x04, then rxValid=0.
//  - FIFO full; rdStrobe coincides with a push of 0x77 -> no overflow, fifoCount stays 4,
//    0x77 is read last.
//  - reset after 6 bits, then a full frame 0xAA (parity 1) -> exactly one byte 0xAA,
//    rxError=0. rdStrobe while empty -> fifoCount stays 0.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the debounced PS/2 lines, deframes
// 11-bit frames, checks parity/stop/timeout and queues good bytes in a small FIFO.
module ps2_rx_fifo #(
    parameter int FIFO_AW        = 2,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ps2Clk,
    input  logic               ps2Data,
    input  logic               rdStrobe,
    input  logic               errClr,
    output logic [7:0]         rxData,
    output logic               rxValid,
    output logic               rxError,
    output logic               overflow,
    output logic [FIFO_AW:0]   fifoCount
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and falling-edge detect
    // ------------------------------------------------------------------
    logic clk_s1, clk_s2, clk_prev;
    logic data_s1, data_s2;
    logic fall;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbours, exactly like the hardware.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2Clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2Data;
            data_s2  <= data_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    // ------------------------------------------------------------------
    // Deframing FSM
    // ------------------------------------------------------------------
    state_t            state, state_nx;
    logic [2:0]        bit_cnt, bit_cnt_nx;
    logic [7:0]        shift_reg, shift_nx;
    logic              par_bit, par_nx;
    logic [TO_W-1:0]   to_cnt, to_nx;
    logic              timeout;
    logic              frame_push;
    logic              frame_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
        end else begin
            state     <= state_nx;
            bit_cnt   <= bit_cnt_nx;
            shift_reg <= shift_nx;
            par_bit   <= par_nx;
            to_cnt    <= to_nx;
        end
    end

    assign timeout = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES));

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift_reg;
        par_nx     = par_bit;
        to_nx      = to_cnt;
        frame_push = 1'b0;
        frame_err  = 1'b0;

        if (state == IDLE || fall) begin
            to_nx = '0;
        end else begin
            to_nx = to_cnt + TO_W'(1);
        end

        if (timeout) begin
            state_nx  = IDLE;
            to_nx     = '0;
            frame_err = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    // A high start bit is treated as line noise, not an error.
                    if (!data_s2) begin
                        state_nx   = DATA;
                        bit_cnt_nx = '0;
                    end
                end
                DATA: begin
                    shift_nx   = {data_s2, shift_reg[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nx = PARITY;
                    end
                end
                PARITY: begin
                    par_nx   = data_s2;
                    state_nx = STOP;
                end
                STOP: begin
                    state_nx = IDLE;
                    if (data_s2 && ^{par_bit, shift_reg}) begin
                        frame_push = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full;
    logic               do_push, do_pop, drop;

    assign full    = count[FIFO_AW];
    assign do_pop  = rdStrobe & rxValid;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
    assign do_push = frame_push & (~full | do_pop);
    assign drop    = frame_push & full & ~do_pop;

    // NOTE: the storage array has no reset; only the pointers and count
    // define what is valid, and rxData is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shift_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rxValid   = |count;
    assign rxData    = rxValid ? mem[rd_ptr] : 8'h00;
    assign fifoCount = count;

    // ------------------------------------------------------------------
    // Sticky status flags; a set event in the same cycle beats errClr
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rxError  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (frame_err) begin
                rxError <= 1'b1;
            end else if (errClr) begin
                rxError <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (errClr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed self-checking bench for ps2_rx_fifo: frame reception, latency, error
// detection, timeout, FIFO overflow / simultaneous push-pop and mid-frame reset.
module tb_ps2_rx_fifo;

    localparam int FIFO_AW        = 2;
    localparam int TIMEOUT_CYCLES = 20000;

    logic             clk;
    logic             reset;
    logic             ps2_clk;
    logic             ps2_data;
    logic             rd_strobe;
    logic             err_clr;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_error;
    logic             overflow;
    logic [FIFO_AW:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_rx_fifo #(
        .FIFO_AW       (FIFO_AW),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2Clk   (ps2_clk),
        .ps2Data  (ps2_data),
        .rdStrobe (rd_strobe),
        .errClr   (err_clr),
        .rxData   (rx_data),
        .rxValid  (rx_valid),
        .rxError  (rx_error),
        .overflow (overflow),
        .fifoCount(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One PS/2 bit: data changes while ps2Clk is high, then a low pulse.
    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] value, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(value[i]);
        end
        send_bit(par);
    endtask

    task automatic send_frame(input logic [7:0] value, input logic par, input logic stop);
        send_head(value, par);
        send_bit(stop);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Stop bit with ps2Clk falling just after a negedge; returns #1 after edge 2.
    task automatic stop_fall();
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic stop_release();
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk);
        rd_strobe = 1'b1;
        @(negedge clk);
        rd_strobe = 1'b0;
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rx_data, rx_valid, rx_error, overflow, fifo_count} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h valid=%b err=%b ovf=%b cnt=%0d, expected all 0",
                     rx_data, rx_valid, rx_error, overflow, fifo_count);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rx_valid, rx_error, overflow, fifo_count} !== 6'h0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got valid=%b err=%b ovf=%b cnt=%0d, expected all 0",
                     rx_valid, rx_error, overflow, fifo_count);
        end
    endtask

    task automatic test_good_frame();
        send_head(8'h1C, 1'b0);
        stop_fall();
        n_checks++;
        if (rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_edge2_valid: got %b expected 0", rx_valid);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (rx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_edge3_valid: got %b expected 1", rx_valid);
        end
        n_checks++;
        if (rx_data !== 8'h1C) begin
            n_fail++;
            $display("FAIL good_data: got %h expected 1c", rx_data);
        end
        n_checks++;
        if (fifo_count !== 3'd1) begin
            n_fail++;
            $display("FAIL good_count: got %0d expected 1", fifo_count);
        end
        stop_release();
        n_checks++;
        if (rx_error !== 1'b0) begin
            n_fail++;
            $display("FAIL good_no_error: got %b expected 0", rx_error);
        end
        pop();
        n_checks++;
        if ({rx_valid, fifo_count} !== 4'b0_000) begin
            n_fail++;
            $display("FAIL good_pop: got valid=%b cnt=%0d expected 0/0", rx_valid, fifo_count);
        end
    endtask

    task automatic test_parity_error();
        send_frame(8'h1C, 1'b1, 1'b1);
        n_checks++;
        if (fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL parity_count: got %0d expected 0", fifo_count);
        end
        n_checks++;
        if (rx_error !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_error: got %b expected 1", rx_error);
        end
        clear_err();
        n_checks++;
        if (rx_error !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_errclr: got %b expected 0", rx_error);
        end
    endtask

    task automatic test_stop_error();
        send_frame(8'h5A, 1'b1, 1'b0);
        n_checks++;
        if (fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL stop_count: got %0d expected 0", fifo_count);
        end
        n_checks++;
        if (rx_error !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_error: got %b expected 1", rx_error);
        end
        clear_err();
    endtask

    task automatic test_timeout();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        n_checks++;
        if (rx_error !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: got %b expected 0", rx_error);
        end
        repeat (TIMEOUT_CYCLES + 5) @(negedge clk);
        n_checks++;
        if (rx_error !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_error: got %b expected 1", rx_error);
        end
        clear_err();
        send_frame(8'hF0, 1'b1, 1'b1);
        n_checks++;
        if ({rx_valid, rx_data, fifo_count} !== {1'b1, 8'hF0, 3'd1}) begin
            n_fail++;
            $display("FAIL timeout_recover: got valid=%b data=%h cnt=%0d expected 1/f0/1",
                     rx_valid, rx_data, fifo_count);
        end
        n_checks++;
        if (rx_error !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_recover_err: got %b expected 0", rx_error);
        end
        pop();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_bytes [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(8'h01, 1'b0, 1'b1);
        send_frame(8'h02, 1'b0, 1'b1);
        send_frame(8'h03, 1'b1, 1'b1);
        send_frame(8'h04, 1'b0, 1'b1);
        n_checks++;
        if ({fifo_count, overflow} !== {3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL full_no_ovf: got cnt=%0d ovf=%b expected 4/0", fifo_count, overflow);
        end
        send_frame(8'h05, 1'b1, 1'b1);
        n_checks++;
        if (fifo_count !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d expected 4", fifo_count);
        end
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag: got %b expected 1", overflow);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({rx_valid, rx_data} !== {1'b1, exp_bytes[i]}) begin
                n_fail++;
                $display("FAIL ovf_read%0d: got valid=%b data=%h expected 1/%h",
                         i, rx_valid, rx_data, exp_bytes[i]);
            end
            pop();
        end
        n_checks++;
        if ({rx_valid, fifo_count} !== 4'b0_000) begin
            n_fail++;
            $display("FAIL ovf_drained: got valid=%b cnt=%0d expected 0/0", rx_valid, fifo_count);
        end
        clear_err();
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_errclr: got %b expected 0", overflow);
        end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp_bytes [4] = '{8'h22, 8'h33, 8'h44, 8'h77};
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        send_frame(8'h33, 1'b1, 1'b1);
        send_frame(8'h44, 1'b1, 1'b1);
        send_head(8'h77, 1'b1);
        stop_fall();
        rd_strobe = 1'b1;
        @(posedge clk);
        #1;
        rd_strobe = 1'b0;
        stop_release();
        n_checks++;
        if ({fifo_count, overflow} !== {3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL pushpop_full: got cnt=%0d ovf=%b expected 4/0", fifo_count, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rx_data !== exp_bytes[i]) begin
                n_fail++;
                $display("FAIL pushpop_read%0d: got %h expected %h", i, rx_data, exp_bytes[i]);
            end
            pop();
        end
        n_checks++;
        if (rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pushpop_drained: got %b expected 0", rx_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_frame(8'hAA, 1'b1, 1'b1);
        n_checks++;
        if ({fifo_count, rx_data} !== {3'd1, 8'hAA}) begin
            n_fail++;
            $display("FAIL midreset_frame: got cnt=%0d data=%h expected 1/aa", fifo_count, rx_data);
        end
        n_checks++;
        if (rx_error !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_error: got %b expected 0", rx_error);
        end
        pop();
        pop();
        n_checks++;
        if ({rx_valid, fifo_count} !== 4'b0_000) begin
            n_fail++;
            $display("FAIL empty_pop: got valid=%b cnt=%0d expected 0/0", rx_valid, fifo_count);
        end
    endtask

    initial begin
        reset     = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        rd_strobe = 1'b0;
        err_clr   = 1'b0;

        test_reset();
        test_good_frame();
        test_parity_error();
        test_stop_error();
        test_timeout();
        test_overflow();
        test_push_pop_full();
        test_reset_mid_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
